// File: rtl/exception_unit_pkg.sv
// Shared trap definitions: cause codes used by this unit and the per-stage pipeline controls.
package exception_unit_pkg;

  localparam logic [2:0] CAUSE_EXT  = 3'b000;
  localparam logic [2:0] CAUSE_ILL  = 3'b001;
  localparam logic [2:0] CAUSE_OVF  = 3'b010;
  localparam logic [2:0] CAUSE_SYS  = 3'b011;
  localparam logic [2:0] CAUSE_NONE = 3'b100;

  // Any cause other than NONE is a synchronous fault raised by the instruction itself.
  function automatic logic is_sync_fault(input logic [2:0] cause);
    return cause != CAUSE_NONE;
  endfunction

endpackage

// File: rtl/exception_unit_irq_sync.sv
// Two-flop synchronizer for the asynchronous interrupt level plus a rising-edge detector.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  output logic irq_edge
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign irq_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/exception_unit.sv
// Trap controller: arbitrates committed-instruction faults against external interrupts,
// saves EPC/cause, and issues the flush + PC redirect for trap entry and eret.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter int unsigned     AW     = 32,
  parameter logic [AW-1:0]   VECTOR = AW'(32'h0000_0080)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ext_irq,
  input  logic          commit_valid,
  input  logic [2:0]    commit_cause,
  input  logic [AW-1:0] commit_pc,
  input  logic          commit_eret,
  input  logic          ie_we,
  input  logic          ie_wdata,
  output logic          interrupts_signal,
  output logic          redirect_valid,
  output logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] epc,
  output logic [2:0]    cause_reg,
  output logic          ie,
  output logic          in_handler,
  output logic          double_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAP,
    S_HANDLER,
    S_RETURN
  } state_e;

  state_e        state_q;
  logic [AW-1:0] epc_q;
  logic [2:0]    cause_q;
  logic          ie_q;
  logic          pending_q;
  logic          df_q;

  logic          irq_edge;
  logic          take_trap;
  logic          take_ext;
  logic [AW-1:0] trap_epc;
  logic [2:0]    trap_cause;

  irq_sync u_irq_sync (
    .clk       (clk),
    .reset     (reset),
    .irq_async (ext_irq),
    .irq_edge  (irq_edge)
  );

  // Trap arbitration in IDLE: own fault, then eret (illegal outside a handler), then interrupt.
  always_comb begin
    take_trap  = 1'b0;
    take_ext   = 1'b0;
    trap_epc   = commit_pc;
    trap_cause = commit_cause;
    if (state_q == S_IDLE && commit_valid) begin
      if (is_sync_fault(commit_cause)) begin
        take_trap = 1'b1;
      end else if (commit_eret) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ILL;
      end else if (pending_q && ie_q) begin
        take_trap  = 1'b1;
        take_ext   = 1'b1;
        trap_cause = CAUSE_EXT;
        trap_epc   = commit_pc + AW'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= CAUSE_NONE;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      df_q      <= 1'b0;
    end else begin
      // A fresh edge arriving as the old request is taken is a new request and stays pending.
      if (irq_edge) begin
        pending_q <= 1'b1;
      end else if (take_ext) begin
        pending_q <= 1'b0;
      end

      if (ie_we) begin
        ie_q <= ie_wdata;
      end

      unique case (state_q)
        S_IDLE: begin
          if (take_trap) begin
            epc_q   <= trap_epc;
            cause_q <= trap_cause;
            state_q <= S_TRAP;
          end
        end
        S_TRAP: begin
          ie_q    <= 1'b0;
          state_q <= S_HANDLER;
        end
        S_HANDLER: begin
          if (commit_valid) begin
            if (commit_eret) begin
              state_q <= S_RETURN;
            end else if (is_sync_fault(commit_cause)) begin
              df_q <= 1'b1;
            end
          end
        end
        S_RETURN: begin
          ie_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (state_q == S_TRAP) begin
      redirect_pc = VECTOR;
    end else if (state_q == S_RETURN) begin
      redirect_pc = epc_q;
    end
  end

  assign interrupts_signal = (state_q == S_TRAP) || (state_q == S_RETURN);
  assign redirect_valid    = interrupts_signal;
  assign epc               = epc_q;
  assign cause_reg         = cause_q;
  assign ie                = ie_q;
  assign in_handler        = (state_q == S_HANDLER);
  assign double_fault      = df_q;

endmodule

// File: tb/tb_exception_unit.sv
// Vector/scoreboard bench for exception_unit: each step drives one cycle of inputs and checks the registered result.
module tb_exception_unit;

  localparam logic [2:0] NO = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_irq;
  logic        commit_valid;
  logic [2:0]  commit_cause;
  logic [31:0] commit_pc;
  logic        commit_eret;
  logic        ie_we;
  logic        ie_wdata;
  logic        interrupts_signal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [2:0]  cause_reg;
  logic        ie;
  logic        in_handler;
  logic        double_fault;

  int total = 0;
  int bad   = 0;
  int stepn = 0;

  always #5 clk = ~clk;

  exception_unit #(.AW(32), .VECTOR(32'h0000_0080)) dut (
    .clk               (clk),
    .reset             (reset),
    .ext_irq           (ext_irq),
    .commit_valid      (commit_valid),
    .commit_cause      (commit_cause),
    .commit_pc         (commit_pc),
    .commit_eret       (commit_eret),
    .ie_we             (ie_we),
    .ie_wdata          (ie_wdata),
    .interrupts_signal (interrupts_signal),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .epc               (epc),
    .cause_reg         (cause_reg),
    .ie                (ie),
    .in_handler        (in_handler),
    .double_fault      (double_fault)
  );

  typedef struct {
    logic        rst;
    logic        cv;
    logic [2:0]  cc;
    logic [31:0] pc;
    logic        er;
    logic        we;
    logic        wd;
    logic        irq;
    logic        x_fl;
    logic [31:0] x_rpc;
    logic [31:0] x_epc;
    logic [2:0]  x_cause;
    logic        x_ie;
    logic        x_inh;
    logic        x_df;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t V(logic rst, logic cv, logic [2:0] cc, logic [31:0] pc, logic er,
                             logic we, logic wd, logic irq, logic fl, logic [31:0] rpc,
                             logic [31:0] xepc, logic [2:0] xc, logic xie, logic inh, logic df);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cc = cc; v.pc = pc; v.er = er; v.we = we; v.wd = wd; v.irq = irq;
    v.x_fl = fl; v.x_rpc = rpc; v.x_epc = xepc; v.x_cause = xc; v.x_ie = xie; v.x_inh = inh; v.x_df = df;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step%0d.%s: got %h want %h", stepn, name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    reset        = v.rst;
    commit_valid = v.cv;
    commit_cause = v.cc;
    commit_pc    = v.pc;
    commit_eret  = v.er;
    ie_we        = v.we;
    ie_wdata     = v.wd;
    ext_irq      = v.irq;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("flush", 32'(interrupts_signal), 32'(e.x_fl));
    chk("rvalid", 32'(redirect_valid), 32'(e.x_fl));
    chk("rpc", redirect_pc, e.x_rpc);
    chk("epc", epc, e.x_epc);
    chk("cause", 32'(cause_reg), 32'(e.x_cause));
    chk("ie", 32'(ie), 32'(e.x_ie));
    chk("inh", 32'(in_handler), 32'(e.x_inh));
    chk("df", 32'(double_fault), 32'(e.x_df));
    stepn++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ext_irq = 1'b0; commit_valid = 1'b0; commit_cause = NO;
    commit_pc = '0; commit_eret = 1'b0; ie_we = 1'b0; ie_wdata = 1'b0;

    //          rst cv cc    pc            er we wd irq   fl rpc       epc       cause ie inh df
    tbl.push_back(V(1, 0, NO,   32'h0,        0, 0, 0, 0,   0, 32'h0,  32'h0,  NO,   0, 0, 0));
    tbl.push_back(V(0, 1, 3'd2, 32'h40,       0, 0, 0, 0,   1, 32'h80, 32'h40, 3'd2, 0, 0, 0));
    tbl.push_back(V(0, 1, 3'd1, 32'h999,      0, 0, 0, 0,   0, 32'h0,  32'h40, 3'd2, 0, 1, 0));
    tbl.push_back(V(0, 1, NO,   32'h50,       1, 0, 0, 0,   1, 32'h40, 32'h40, 3'd2, 0, 0, 0));
    tbl.push_back(V(0, 0, NO,   32'h0,        0, 0, 0, 0,   0, 32'h0,  32'h40, 3'd2, 1, 0, 0));
    tbl.push_back(V(0, 1, NO,   32'h60,       1, 0, 0, 0,   1, 32'h80, 32'h60, 3'd1, 1, 0, 0));
    tbl.push_back(V(0, 0, NO,   32'h0,        0, 1, 1, 0,   0, 32'h0,  32'h60, 3'd1, 0, 1, 0));
    tbl.push_back(V(0, 1, 3'd1, 32'h70,       0, 0, 0, 0,   0, 32'h0,  32'h60, 3'd1, 0, 1, 1));
    tbl.push_back(V(0, 0, NO,   32'h0,        0, 1, 1, 0,   0, 32'h0,  32'h60, 3'd1, 1, 1, 1));
    tbl.push_back(V(0, 1, NO,   32'h74,       1, 0, 0, 0,   1, 32'h60, 32'h60, 3'd1, 1, 0, 1));
    tbl.push_back(V(0, 0, NO,   32'h0,        0, 1, 0, 0,   0, 32'h0,  32'h60, 3'd1, 1, 0, 1));
    tbl.push_back(V(0, 1, NO,   32'hFFFF_FFFC,0, 0, 0, 0,   0, 32'h0,  32'h60, 3'd1, 1, 0, 1));
    tbl.push_back(V(1, 0, NO,   32'h0,        0, 0, 0, 0,   0, 32'h0,  32'h0,  NO,   0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);

    // External request latency and EPC = PC+4; commit on the edge that sets pending does not trap.
    step(V(0, 0, NO, 32'h0,   0, 1, 1, 0,  0, 32'h0,   32'h0,   NO,   1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 1,  0, 32'h0,   32'h0,   NO,   1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   1, 0, 0));
    step(V(0, 1, NO, 32'h10,  0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   1, 0, 0));
    step(V(0, 1, NO, 32'h100, 0, 0, 0, 0,  1, 32'h80,  32'h104, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h104, 3'd0, 0, 1, 0));
    step(V(0, 1, NO, 32'h20,  1, 0, 0, 0,  1, 32'h104, 32'h104, 3'd0, 0, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h104, 3'd0, 1, 0, 0));
    step(V(0, 1, NO, 32'h300, 0, 0, 0, 0,  0, 32'h0,   32'h104, 3'd0, 1, 0, 0));

    // Synchronous trap beats pending interrupt, which is then taken after eret.
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 1,  0, 32'h0,   32'h104, 3'd0, 1, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h104, 3'd0, 1, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h104, 3'd0, 1, 0, 0));
    step(V(0, 1, 3'd3, 32'h200, 0, 0, 0, 0,  1, 32'h80,  32'h200, 3'd3, 1, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h200, 3'd3, 0, 1, 0));
    step(V(0, 1, NO,   32'h30,  1, 0, 0, 0,  1, 32'h200, 32'h200, 3'd3, 0, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h200, 3'd3, 1, 0, 0));
    step(V(0, 1, NO,   32'h210, 0, 0, 0, 0,  1, 32'h80,  32'h214, 3'd0, 1, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h214, 3'd0, 0, 1, 0));
    step(V(0, 1, NO,   32'h40,  1, 0, 0, 0,  1, 32'h214, 32'h214, 3'd0, 0, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h214, 3'd0, 1, 0, 0));

    // Masking: pending held while ie=0 and while no commit; then PC+4 wrap.
    step(V(0, 0, NO, 32'h0,   0, 1, 0, 0,  0, 32'h0,   32'h214, 3'd0, 0, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 1,  0, 32'h0,   32'h214, 3'd0, 0, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h214, 3'd0, 0, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h214, 3'd0, 0, 0, 0));
    step(V(0, 1, NO, 32'h400, 0, 0, 0, 0,  0, 32'h0,   32'h214, 3'd0, 0, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 1, 1, 0,  0, 32'h0,   32'h214, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h214, 3'd0, 1, 0, 0));
    step(V(0, 1, NO, 32'h500, 0, 0, 0, 0,  1, 32'h80,  32'h504, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h504, 3'd0, 0, 1, 0));
    step(V(0, 1, NO, 32'h50,  1, 0, 0, 0,  1, 32'h504, 32'h504, 3'd0, 0, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h504, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 1,  0, 32'h0,   32'h504, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h504, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h504, 3'd0, 1, 0, 0));
    step(V(0, 1, NO, 32'hFFFF_FFFC, 0, 0, 0, 0,  1, 32'h80, 32'h0, 3'd0, 1, 0, 0));
    step(V(0, 0, NO, 32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   3'd0, 0, 1, 0));

    // Reset in the TRAP cycle and in the RETURN cycle suppresses the flush.
    step(V(1, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   0, 0, 0));
    step(V(0, 1, 3'd1, 32'h600, 0, 0, 0, 0,  1, 32'h80,  32'h600, 3'd1, 0, 0, 0));
    step(V(1, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   0, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   0, 0, 0));
    step(V(0, 1, 3'd2, 32'h700, 0, 0, 0, 0,  1, 32'h80,  32'h700, 3'd2, 0, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h700, 3'd2, 0, 1, 0));
    step(V(0, 1, NO,   32'h60,  1, 0, 0, 0,  1, 32'h700, 32'h700, 3'd2, 0, 0, 0));
    step(V(1, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   0, 0, 0));
    step(V(0, 0, NO,   32'h0,   0, 0, 0, 0,  0, 32'h0,   32'h0,   NO,   0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
# exception_unit

Consumer end of the per-stage cause/flush interface. It samples the 3-bit cause code and PC of the instruction leaving the last pipeline stage, and accepts external interrupt requests. It arbitrates between them, latches EPC/cause, and drives the `interrupts_signal` flush pulse and PC redirect back to the fetch-stage control. It also handles `eret` return.

## Interface
- `VECTOR`, 32'h0000_0080, handler entry address
- `AW`, 32, PC width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `ext_irq`  in  1  external request, asynchronous level
- `commit_valid`  in  1  an instruction leaves the last stage this cycle
- `commit_cause`  in  3  cause code of that instruction (100 = none)
- `commit_pc`  in  AW  PC of that instruction
- `commit_eret`  in  1  committing instruction is `eret`
- `ie_we`  in  1  software write of the interrupt-enable bit
- `ie_wdata`  in  1  value for `ie_we`
- `interrupts_signal`  out  1  one-cycle pipeline flush pulse
- `redirect_valid`  out  1  PC load from `redirect_pc`; same cycle as the flush
- `redirect_pc`  out  AW  target PC
- `epc`  out  AW  saved return address
- `cause_reg`  out  3  cause of the last trap taken
- `ie`  out  1  interrupt enable
- `in_handler`  out  1  high while in HANDLER
- `double_fault`  out  1  sticky; set by a synchronous exception inside the handler

## Operation
- Cause codes: 000 external, 001 illegal instruction, 010 ALU overflow, 011 syscall, 100 none.
- `ext_irq` passes through a 2-flop synchronizer. A rising edge of the synchronized signal sets `pending`. `pending` clears only when an external trap is taken.
- States: IDLE, TRAP, HANDLER, RETURN.
- IDLE, when `commit_valid`:
  - `commit_cause` != 100: synchronous trap. Latch `epc <= commit_pc` and `cause_reg <= commit_cause`. Go to TRAP.
  - Else if `commit_eret`: treated as an illegal instruction (cause 001, `epc <= commit_pc`). Go to TRAP.
  - Else if `pending && ie`: external trap. Latch `epc <= commit_pc + 4` (the instruction completes), `cause_reg <= 000`, clear `pending`. Go to TRAP.
  - A synchronous trap wins over a pending external request; `pending` is retained.
- IDLE with `commit_valid` = 0: no action, even if `pending && ie`.
- TRAP, one cycle:
  - `interrupts_signal` = 1, `redirect_valid` = 1, `redirect_pc` = `VECTOR`.
  - `ie <= 0`, then go to HANDLER.
  - Commit inputs are ignored in this cycle (the pipeline is being flushed).
- HANDLER:
  - `commit_eret` with `commit_valid`: go to RETURN.
  - Synchronous cause != 100: set `double_fault`; `epc` and `cause_reg` are unchanged; no trap.
  - External requests stay pending.
- RETURN, one cycle:
  - `interrupts_signal` = 1, `redirect_valid` = 1, `redirect_pc` = `epc`.
  - `ie <= 1`, then go to IDLE.
- `ie_we` updates `ie` in any state except TRAP and RETURN. In those two states the hardware update to `ie` wins.
- `AW` arithmetic for `commit_pc + 4` wraps modulo 2^AW.

## Timing
- Reset values: state IDLE, `interrupts_signal` 0, `redirect_valid` 0, `redirect_pc` 0, `epc` 0, `cause_reg` 100, `ie` 0, `in_handler` 0, `double_fault` 0, `pending` 0, synchronizer flops 0.
- All outputs are registered, or decoded from state only.
- Commit sampled at edge N → flush and redirect high for exactly cycle N+1 → `in_handler` high from N+2.
- `ext_irq` rise → `pending` set 3 edges later (2 synchronizer flops plus the edge-detect register).
- Reset asserted mid-TRAP or mid-RETURN: the next cycle is IDLE with all reset values; no flush is emitted.

## Structure
- Cause constants (CAUSE_EXT, CAUSE_ILL, CAUSE_OVF, CAUSE_SYS, CAUSE_NONE) go in shared header `general_architecture/causes.vh`. The per-stage pipeline control blocks use the same header.
- State encoding is local to this block.
- Sub-module `irq_sync`: 2-flop synchronizer plus rising-edge detector; outputs a one-cycle `irq_edge`.

## Test plan
- Overflow: in IDLE, commit cause 010 at PC 0x0000_0040 → next cycle: flush = 1, `redirect_pc` = 0x80, `epc` = 0x40, `cause_reg` = 010, `ie` = 0.
- External: `ie` = 1, pulse `ext_irq`, then commit PC 0x100 with cause 100 → trap with `epc` = 0x104, `cause_reg` = 000, `pending` cleared.
- Priority: `pending` set and commit cause 011 at PC 0x200 in the same cycle → `cause_reg` = 011, `epc` = 0x200. After `eret`, the next commit traps with cause 000.
- Return: in HANDLER with `epc` = 0x104, commit `eret` → one-cycle flush, `redirect_pc` = 0x104, `ie` = 1, state IDLE.
- Nesting and masking: commit cause 001 in HANDLER → `double_fault` = 1, `epc` unchanged. With `ie` = 0, `ext_irq` pulses → no trap until `ie_we` sets 1 and a commit occurs.
- Reset: assert `reset` in the TRAP cycle → next cycle all outputs at reset values, no redirect.
